// File: rtl/mem_responder.sv
// mem_responder: byte-wide single responder for the memory controller bus.
// Backs a 2^ADDR_WIDTH-byte RAM. When MEM_RESPONDER_IO_EN is defined, it also
// decodes an IO page (addr[17:16]==2'b11) holding a console TX FIFO at offset
// 0x00 and a sticky simulation-halt register at offset 0x04. When the macro is
// undefined, every address maps to RAM and all IO outputs are tied to zero.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned IO_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_addr_in,
  input  logic        mem_wr_in,
  input  logic [7:0]  mem_wdata_in,
  output logic [7:0]  mem_data_out,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  output logic        io_buffer_full,
  output logic        io_overflow,
  output logic        sim_halt,
  output logic [7:0]  halt_code
);

  localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;

  logic [7:0]            ram_q [RAM_BYTES];
  logic [ADDR_WIDTH-1:0] idx_c;
  logic                  io_sel_c;
  logic [7:0]            io_rdata_c;
  logic [7:0]            data_q;
  logic [7:0]            data_d;
  logic                  unused_c;

  assign idx_c = mem_addr_in[ADDR_WIDTH-1:0];

  // Address bits above the decoded range are intentionally ignored.
  assign unused_c = ^{mem_addr_in, io_tx_ready};

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rdy && mem_wr_in && !io_sel_c) begin
      ram_q[idx_c] <= mem_wdata_in;
    end
  end

  // Read data mux: reads update the output, writes leave it holding.
  always_comb begin
    data_d = data_q;
    if (rdy && !mem_wr_in) begin
      data_d = io_sel_c ? io_rdata_c : ram_q[idx_c];
    end
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign mem_data_out = data_q;

`ifdef MEM_RESPONDER_IO_EN

  localparam int unsigned PTR_W = $clog2(IO_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IO_FIFO_DEPTH);

  logic [7:0]       fifo_q [IO_FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             ovf_q, ovf_d;
  logic             halt_q, halt_d;
  logic [7:0]       code_q, code_d;

  logic [7:0]       offset_c;
  logic             push_req_c;
  logic             push_ok_c;
  logic             pop_c;
  logic             halt_wr_c;
  logic             is_full_c;

  assign io_sel_c = (mem_addr_in[17:16] == 2'b11);
  assign offset_c = mem_addr_in[7:0];

  // IO read data: status register at 0x04, zero elsewhere.
  assign io_rdata_c = (offset_c == 8'h04) ? {7'b0, full_q} : 8'h00;

  // Push/pop qualification; a pop frees room for a same-cycle push.
  always_comb begin
    push_req_c = rdy && mem_wr_in && io_sel_c && (offset_c == 8'h00);
    halt_wr_c  = rdy && mem_wr_in && io_sel_c && (offset_c == 8'h04);
    pop_c      = rdy && io_tx_ready && (count_q != '0);
    is_full_c  = (count_q == DEPTH_C);
    push_ok_c  = push_req_c && (!is_full_c || pop_c);
  end

  // FIFO storage write at the tail.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      fifo_q[tail_q] <= mem_wdata_in;
    end
  end

  // Next-state for pointers, count, status flags, head byte and halt register.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    halt_d    = halt_q;
    code_d    = code_q;
    tx_data_d = 8'h00;

    if (pop_c) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push_ok_c) begin
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);

    if (push_req_c && is_full_c && !pop_c) begin
      ovf_d = 1'b1;
    end
    if (halt_wr_c) begin
      halt_d = 1'b1;
      code_d = mem_wdata_in;
    end

    valid_d = (count_d != '0);
    full_d  = (count_d == DEPTH_C);

    // Head byte may be the one being written this cycle.
    if (count_d != '0) begin
      if (push_ok_c && (tail_q == head_d)) begin
        tx_data_d = mem_wdata_in;
      end else begin
        tx_data_d = fifo_q[head_d];
      end
    end
  end

  // IO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
      code_q    <= 8'h00;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_d;
      code_q    <= code_d;
    end
  end

  assign io_tx_valid    = valid_q;
  assign io_tx_data     = tx_data_q;
  assign io_buffer_full = full_q;
  assign io_overflow    = ovf_q;
  assign sim_halt       = halt_q;
  assign halt_code      = code_q;

`else

  assign io_sel_c       = 1'b0;
  assign io_rdata_c     = 8'h00;
  assign io_tx_valid    = 1'b0;
  assign io_tx_data     = 8'h00;
  assign io_buffer_full = 1'b0;
  assign io_overflow    = 1'b0;
  assign sim_halt       = 1'b0;
  assign halt_code      = 8'h00;

`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: RAM vector table plus hand-written
// IO FIFO / halt / reset sequences (IO part follows MEM_RESPONDER_IO_EN).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_addr_in;
  logic        mem_wr_in;
  logic [7:0]  mem_wdata_in;
  logic [7:0]  mem_data_out;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        io_buffer_full;
  logic        io_overflow;
  logic        sim_halt;
  logic [7:0]  halt_code;

  int n_chk  = 0;
  int n_pass = 0;

  mem_responder #(.ADDR_WIDTH(17), .IO_FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_addr_in    (mem_addr_in),
    .mem_wr_in      (mem_wr_in),
    .mem_wdata_in   (mem_wdata_in),
    .mem_data_out   (mem_data_out),
    .io_tx_valid    (io_tx_valid),
    .io_tx_data     (io_tx_data),
    .io_tx_ready    (io_tx_ready),
    .io_buffer_full (io_buffer_full),
    .io_overflow    (io_overflow),
    .sim_halt       (sim_halt),
    .halt_code      (halt_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rdy;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [7:0] d, input logic txr);
    rdy          = r;
    mem_wr_in    = w;
    mem_addr_in  = a;
    mem_wdata_in = d;
    io_tx_ready  = txr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(mem_data_out),   32'h0);
    check({tag, "_valid"}, 32'(io_tx_valid),    32'h0);
    check({tag, "_txd"},   32'(io_tx_data),     32'h0);
    check({tag, "_full"},  32'(io_buffer_full), 32'h0);
    check({tag, "_ovf"},   32'(io_overflow),    32'h0);
    check({tag, "_halt"},  32'(sim_halt),       32'h0);
    check({tag, "_code"},  32'(halt_code),      32'h0);
  endtask

  initial begin
    logic [7:0] drain [8];

    // name, rdy, wr, addr, wdata, expected mem_data_out after the edge
    vecs[0]  = '{"wr_10_a5",     1'b1, 1'b1, 32'h0000_0010, 8'hA5, 8'h00};
    vecs[1]  = '{"rd_10",        1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[2]  = '{"wr_0_13",      1'b1, 1'b1, 32'h0000_0000, 8'h13, 8'hA5};
    vecs[3]  = '{"wr_1_00",      1'b1, 1'b1, 32'h0000_0001, 8'h00, 8'hA5};
    vecs[4]  = '{"wr_2_00",      1'b1, 1'b1, 32'h0000_0002, 8'h00, 8'hA5};
    vecs[5]  = '{"wr_3_00",      1'b1, 1'b1, 32'h0000_0003, 8'h00, 8'hA5};
    vecs[6]  = '{"rd_0",         1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h13};
    vecs[7]  = '{"rd_1",         1'b1, 1'b0, 32'h0000_0001, 8'h00, 8'h00};
    vecs[8]  = '{"rd_2",         1'b1, 1'b0, 32'h0000_0002, 8'h00, 8'h00};
    vecs[9]  = '{"rd_3",         1'b1, 1'b0, 32'h0000_0003, 8'h00, 8'h00};
    vecs[10] = '{"rd_10_again",  1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[11] = '{"nordy_wr_ff",  1'b0, 1'b1, 32'h0000_0010, 8'hFF, 8'hA5};
    vecs[12] = '{"rd_10_unchg",  1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[13] = '{"nordy_rd_0",   1'b0, 1'b0, 32'h0000_0000, 8'h00, 8'hA5};
    vecs[14] = '{"rd_alias_hi",  1'b1, 1'b0, 32'hFFFA_0010, 8'h00, 8'hA5};
    vecs[15] = '{"wr_top_77",    1'b1, 1'b1, 32'h0001_FFFF, 8'h77, 8'hA5};
    vecs[16] = '{"rd_top",       1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 8'h77};
    vecs[17] = '{"wr_10_3c",     1'b1, 1'b1, 32'h0000_0010, 8'h3C, 8'h77};
    vecs[18] = '{"rd_10_new",    1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'h3C};

    rst = 1'b1; rdy = 1'b1; mem_wr_in = 1'b0; mem_addr_in = '0;
    mem_wdata_in = '0; io_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // RAM table
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
      check(vecs[i].name, 32'(mem_data_out), 32'(vecs[i].exp_data));
    end
    check("ram_no_tx_valid", 32'(io_tx_valid), 32'h0);

`ifdef MEM_RESPONDER_IO_EN
    // Fill FIFO with 0x41..0x48, no consumer
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'h0003_0000, 8'(8'h41 + i), 1'b0);
      check("fill_valid", 32'(io_tx_valid), 32'h1);
      check("fill_full", 32'(io_buffer_full), (i == 7) ? 32'h1 : 32'h0);
      check("fill_head", 32'(io_tx_data), 32'h41);
    end
    check("fill_no_ovf", 32'(io_overflow), 32'h0);

    // Full with simultaneous pop and push 0x5A
    step(1'b1, 1'b1, 32'h0003_0000, 8'h5A, 1'b1);
    check("pp_full", 32'(io_buffer_full), 32'h1);
    check("pp_no_ovf", 32'(io_overflow), 32'h0);
    check("pp_head", 32'(io_tx_data), 32'h42);

    // Push while full without pop: dropped
    step(1'b1, 1'b1, 32'h0003_0000, 8'h49, 1'b0);
    check("drop_ovf", 32'(io_overflow), 32'h1);
    check("drop_full", 32'(io_buffer_full), 32'h1);
    check("drop_head", 32'(io_tx_data), 32'h42);

    step(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0);
    check("rd_status_full", 32'(mem_data_out), 32'h01);
    step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0);
    check("rd_txreg", 32'(mem_data_out), 32'h00);
    step(1'b1, 1'b0, 32'h0003_0008, 8'h00, 1'b0);
    check("rd_other", 32'(mem_data_out), 32'h00);

    // rdy low with consumer ready: no pop
    step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("nordy_head", 32'(io_tx_data), 32'h42);
    check("nordy_full", 32'(io_buffer_full), 32'h1);

    // Drain in order
    for (int j = 0; j < 7; j++) drain[j] = 8'(8'h42 + j);
    drain[7] = 8'h5A;
    for (int j = 0; j < 8; j++) begin
      check("drain_valid", 32'(io_tx_valid), 32'h1);
      check("drain_data", 32'(io_tx_data), 32'(drain[j]));
      step(1'b1, 1'b0, 32'h0, 8'h00, 1'b1);
      if (j == 0) check("drain_not_full", 32'(io_buffer_full), 32'h0);
    end
    check("empty_valid", 32'(io_tx_valid), 32'h0);
    check("empty_data", 32'(io_tx_data), 32'h0);
    check("ovf_sticky", 32'(io_overflow), 32'h1);
    step(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0);
    check("rd_status_empty", 32'(mem_data_out), 32'h00);

    // Halt register
    step(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0);
    check("halt_set", 32'(sim_halt), 32'h1);
    check("halt_code0", 32'(halt_code), 32'h00);
    step(1'b1, 1'b1, 32'h0003_0004, 8'h5C, 1'b0);
    check("halt_still", 32'(sim_halt), 32'h1);
    check("halt_code5c", 32'(halt_code), 32'h5C);

    // IO writes do not touch RAM
    step(1'b1, 1'b1, 32'h0003_0010, 8'hEE, 1'b0);
    step(1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0);
    check("ram_untouched", 32'(mem_data_out), 32'h3C);
    step(1'b1, 1'b0, 32'h0003_0010, 8'h00, 1'b0);
    check("rd_io_10", 32'(mem_data_out), 32'h00);

    step(1'b1, 1'b1, 32'h0003_0000, 8'h11, 1'b0);
    check("push_after_halt", 32'(io_tx_data), 32'h11);
`else
    // Without IO decode, IO-page addresses are plain RAM
    step(1'b1, 1'b1, 32'h0003_0000, 8'h41, 1'b0);
    step(1'b1, 1'b0, 32'h0001_0000, 8'h00, 1'b0);
    check("noio_alias", 32'(mem_data_out), 32'h41);
    step(1'b1, 1'b1, 32'h0003_0004, 8'h99, 1'b0);
    check("noio_halt", 32'(sim_halt), 32'h0);
    check("noio_code", 32'(halt_code), 32'h0);
    check("noio_valid", 32'(io_tx_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0);
    check("noio_rd_4", 32'(mem_data_out), 32'h99);
`endif

    // Asynchronous reset mid-cycle
    step(1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0);
    check("pre_rst_data", 32'(mem_data_out), 32'h3C);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0);
    check("post_rst_ram", 32'(mem_data_out), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory responder that serves the instruction/data memory controller's byte bus. It backs a RAM of 2^ADDR_WIDTH bytes and a small memory-mapped IO page. The IO page holds a transmit FIFO for console output and a simulation-halt register. It sits between the memory controller's `mem_addr_out`/`mem_dout`/`mem_wr` outputs and its `mem_data_in` input, and is the bus's single responder.

## Interface
- `ADDR_WIDTH`, 17: RAM byte-address bits; RAM size 2^ADDR_WIDTH bytes.
- `IO_FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable; when low, no state changes.
- `mem_addr_in` in 32: byte address from the controller.
- `mem_wr_in` in 1: 1 = write this cycle, 0 = read.
- `mem_wdata_in` in 8: write byte.
- `mem_data_out` out 8: read byte, registered.
- `io_tx_valid` out 1: TX FIFO non-empty.
- `io_tx_data` out 8: FIFO head byte.
- `io_tx_ready` in 1: consumer accepts head this cycle.
- `io_buffer_full` out 1: TX FIFO full.
- `io_overflow` out 1: sticky; a push was dropped.
- `sim_halt` out 1: sticky halt request.
- `halt_code` out 8: byte written to the halt register.

## Operation
- Decode: `mem_addr_in[17:16]==2'b11` selects the IO page; otherwise the access is RAM at index `mem_addr_in[ADDR_WIDTH-1:0]`, with upper bits ignored.
- RAM write (`rdy` && `mem_wr_in` && RAM): `ram[idx] <= mem_wdata_in`.
- RAM read (`rdy` && !`mem_wr_in` && RAM): `mem_data_out <= ram[idx]`.
- Reads have no side effects anywhere. The controller drives address 0 with `mem_wr`=0 when idle, and these idle reads are harmless.
- Write cycles do not update `mem_data_out`; it holds its previous value.
- IO page, low byte of address:
  - 0x00 write: push `mem_wdata_in` into the TX FIFO.
  - 0x00 read: returns 0x00.
  - 0x04 write: `sim_halt <= 1`, `halt_code <= mem_wdata_in`.
  - 0x04 read: returns `{7'b0, io_buffer_full}`.
  - Other offsets: writes ignored, reads return 0x00.
- TX FIFO:
  - Circular buffer with head/tail pointers and a count.
  - `io_tx_valid` = count≠0.
  - `io_tx_data` = `buf[head]`, or 0x00 when empty.
  - Pop on `io_tx_valid` && `io_tx_ready` && `rdy`.
  - Push and pop in the same cycle: both happen, and the count is unchanged.
  - Push when full with no simultaneous pop: byte dropped, `io_overflow <= 1`, which stays set until reset.
  - Push when full with a simultaneous pop: push accepted.
  - Pointers wrap modulo IO_FIFO_DEPTH.
  - `io_buffer_full` = (count == IO_FIFO_DEPTH).
- `sim_halt`: once set, later halt-register writes update `halt_code` only. The RAM and FIFO keep operating.
- `rdy` low: RAM, FIFO, pointers, halt and all outputs hold. A pending `io_tx_ready` is ignored.

## Timing
- Read latency is one cycle. Address A is presented with `mem_wr_in`=0 at edge N, and `ram[A]` appears on `mem_data_out` after edge N, so the controller samples it at edge N+1. This matches the controller's two-stage sent pipeline.
- A write at edge N followed by a read of the same address at edge N+1 returns the new byte after edge N+1.
- Back-to-back accesses are accepted every cycle, with no stalls and no backpressure to the controller.
- FIFO status (`io_tx_valid`, `io_buffer_full`) reflects a push or pop the cycle after the edge.
- Reset values: `mem_data_out` 0, `io_tx_valid` 0, `io_tx_data` 0, `io_buffer_full` 0, `io_overflow` 0, `sim_halt` 0, `halt_code` 0; FIFO pointers and count 0.
- RAM contents are not reset.
- Reset mid-operation discards FIFO contents and halt state immediately (asynchronous).

## Configuration
- `MEM_RESPONDER_IO_EN` defined: IO page decoded as above.
- `MEM_RESPONDER_IO_EN` undefined: no IO decode; every address maps to RAM via `idx`. The FIFO and halt logic are not built. `io_tx_valid`, `io_tx_data`, `io_buffer_full`, `io_overflow`, `sim_halt` and `halt_code` are tied to 0.

## Test plan
- Write 0xA5 to 0x00000010, then read 0x10 next cycle -> `mem_data_out`=0xA5 one cycle after the read address.
- Write 4 bytes 0x13,0x00,0x00,0x00 to 0x0..0x3, then read them back-to-back -> 0x13,0x00,0x00,0x00 on consecutive cycles. During the writes, `mem_data_out` holds its prior value.
- `io_tx_ready`=0, 9 writes of 0x41..0x49 to 0x30000 -> `io_buffer_full`=1 after 8; 9th dropped with `io_overflow`=1; read 0x30004 returns 0x01. Then hold `io_tx_ready`=1 -> bytes 0x41..0x48 out in order, `io_tx_valid` falls after the 8th.
- FIFO full with `io_tx_ready`=1 and a simultaneous push of 0x5A -> count stays 8, no overflow; 0x5A is drained last.
- Write 0x00 to 0x30004 -> `sim_halt`=1, `halt_code`=0x00; an asynchronous `rst` pulse mid-burst -> all outputs 0 immediately.
- `rdy`=0 during a write of 0xFF to 0x10 -> `ram[0x10]` unchanged; `rdy`=0 with `io_tx_ready`=1 -> no pop.
